// File: rtl/mips_mem_pkg.sv
// Shared constants for the data-memory responder: read modes, FSM encoding
// and the default storage size.
package mips_mem_pkg;

    localparam int unsigned DEPTH_BYTES_DEF = 1024;

    localparam logic [1:0] RM_NONE = 2'b00;
    localparam logic [1:0] RM_LW   = 2'b01;
    localparam logic [1:0] RM_LH   = 2'b10;
    localparam logic [1:0] RM_LHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-addressed storage with a 4-byte big-endian write port (per-byte
// enable) and a 4-byte asynchronous big-endian read port.
module dm_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // Zero at simulation start only; reset never touches storage.
    logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

    // Lane i maps to byte address a+i and to the i-th most significant byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i + AW'(i)] <= wdata_i[31-8*i -: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_o[31-8*i -: 8] = mem_q[raddr_i + AW'(i)];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: IDLE -> BUSY (LATENCY cycles)
// -> RESP, with alignment/range checking and big-endian byte storage.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_read_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [1:0]  mode_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        is_word, is_half, misaligned, out_of_range;
    logic        err_d, commit;
    logic [32:0] last_byte;
    logic [31:0] rd_word, rdata_d;
    logic [3:0]  we;

    // Decode of the captured request; a store overrides any read mode.
    always_comb begin
        is_word      = write_q || (mode_q == RM_LW);
        is_half      = !write_q && ((mode_q == RM_LH) || (mode_q == RM_LHU));
        misaligned   = (is_word && (addr_q[1:0] != 2'b00)) || (is_half && addr_q[0]);
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        last_byte    = {1'b0, addr_q} + (is_word ? 33'd3 : 33'd1);
        out_of_range = (is_word || is_half) && (last_byte >= 33'(DEPTH_BYTES));
        err_d        = misaligned || out_of_range;
    end

    assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    // Reset in the commit cycle discards the store.
    assign we     = {4{commit && write_q && !err_d && !reset}};

    dm_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    always_comb begin
        rdata_d = '0;
        if (!err_d && !write_q) begin
            case (mode_q)
                RM_LW:   rdata_d = rd_word;
                RM_LH:   rdata_d = {{16{rd_word[31]}}, rd_word[31:16]};
                RM_LHU:  rdata_d = {16'h0000, rd_word[31:16]};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            mode_q      <= RM_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        mode_q  <= req_read_mode;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q     <= rdata_d;
                        err_q       <= err_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus randomized
// traffic checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_read_mode = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_read_mode (req_read_mode),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_m [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          bp_hold = 0;
    bit          bp_rand = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain byte array, sizes and rules straight from the ISA view.
    function automatic void model(input bit w, input logic [1:0] m, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int size;
        longint unsigned lastb;
        size = w ? 4 : (m == 2'b00 ? 0 : (m == 2'b01 ? 4 : 2));
        rd = 32'h0;
        e  = 1'b0;
        if (size == 0) return;
        lastb = 64'(a) + 64'(size) - 64'd1;
        if ((a % size) != 0 || lastb >= 64'(DEPTH)) begin
            e = 1'b1;
            return;
        end
        if (w) begin
            mem_m[a]     = wd[31:24];
            mem_m[a + 1] = wd[23:16];
            mem_m[a + 2] = wd[15:8];
            mem_m[a + 3] = wd[7:0];
        end else if (m == 2'b01) begin
            rd = {mem_m[a], mem_m[a + 1], mem_m[a + 2], mem_m[a + 3]};
        end else if (m == 2'b10) begin
            rd = {{16{mem_m[a][7]}}, mem_m[a], mem_m[a + 1]};
        end else begin
            rd = {16'h0000, mem_m[a], mem_m[a + 1]};
        end
    endfunction

    task automatic send(input bit w, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input bit track);
        int n;
        exp_t e;
        logic [31:0] rd;
        logic er;
        n = 0;
        @(negedge clk);
        while (!req_ready) begin
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL req_ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
                return;
            end
            @(negedge clk);
        end
        req_valid     = 1'b1;
        req_write     = w;
        req_read_mode = m;
        req_addr      = a;
        req_wdata     = wd;
        if (track) begin
            model(w, m, a, wd, rd, er);
            e.rdata = rd;
            e.err   = er;
            e.acc   = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", q.size());
        end
    endtask

    // Response-side handshake driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_hold ? 1'b0 : (bp_rand ? 1'($urandom % 2) : 1'b1);
        end
    end

    // Monitor: latency on first sight, stability while held, data on handshake.
    initial begin
        bit          seen;
        logic [31:0] hold_d;
        logic        hold_e;
        exp_t        e;
        seen = 0;
        hold_d = '0;
        hold_e = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    if (!seen) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=valid expected=none rdata=%h (cycle %0d)",
                                 rsp_rdata, cyc);
                    end
                    seen = !rsp_ready;
                end else begin
                    if (!seen) begin
                        seen   = 1;
                        hold_d = rsp_rdata;
                        hold_e = rsp_err;
                        check("latency", 32'(cyc + 1 - q[0].acc), 32'(LAT + 1));
                    end else begin
                        check("hold_rdata", rsp_rdata, hold_d);
                        check("hold_err", 32'(rsp_err), 32'(hold_e));
                    end
                    if (rsp_ready) begin
                        e = q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        last_rdata = rsp_rdata;
                        last_err   = rsp_err;
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] held;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        send(1, 2'b00, 32'd0, 32'h12345678, 1); drain();
        check("sw0_rdata", last_rdata, 32'h0);
        check("sw0_err", 32'(last_err), 32'd0);
        send(0, 2'b01, 32'd0, 32'h0, 1); drain();
        check("lw0_rdata", last_rdata, 32'h12345678);
        check("lw0_err", 32'(last_err), 32'd0);

        send(1, 2'b00, 32'd4, 32'h80011234, 1); drain();
        send(0, 2'b10, 32'd4, 32'h0, 1); drain();
        check("lh4", last_rdata, 32'hFFFF8001);
        send(0, 2'b11, 32'd4, 32'h0, 1); drain();
        check("lhu4", last_rdata, 32'h00008001);

        send(0, 2'b01, 32'd2, 32'h0, 1); drain();
        check("lw2_err", 32'(last_err), 32'd1);
        check("lw2_rdata", last_rdata, 32'h0);
        send(1, 2'b00, 32'd1020, 32'hCAFEF00D, 1); drain();
        send(1, 2'b00, 32'd1022, 32'h11111111, 1); drain();
        check("sw1022_err", 32'(last_err), 32'd1);
        send(0, 2'b01, 32'd1020, 32'h0, 1); drain();
        check("lw1020", last_rdata, 32'hCAFEF00D);
        send(0, 2'b11, 32'd1022, 32'h0, 1); drain();
        check("lhu1022", last_rdata, 32'h0000F00D);
        send(0, 2'b10, 32'd1023, 32'h0, 1); drain();
        check("lh1023_err", 32'(last_err), 32'd1);
        send(0, 2'b01, 32'hFFFFFFFC, 32'h0, 1); drain();
        check("lw_wrap_err", 32'(last_err), 32'd1);
        send(0, 2'b00, 32'd3, 32'h0, 1); drain();
        check("nop_rdata", last_rdata, 32'h0);
        check("nop_err", 32'(last_err), 32'd0);
        send(1, 2'b01, 32'd12, 32'h0BADF00D, 1); drain();
        send(0, 2'b01, 32'd12, 32'h0, 1); drain();
        check("sw_prio", last_rdata, 32'h0BADF00D);

        // Back-pressure: response held, new requests ignored until handshake.
        bp_hold = 1;
        send(0, 2'b01, 32'd0, 32'h0, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        held          = rsp_rdata;
        req_valid     = 1'b1;
        req_write     = 1'b1;
        req_read_mode = 2'b00;
        req_addr      = 32'h40;
        req_wdata     = 32'hA5A5A5A5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rdata", rsp_rdata, 32'h12345678);
        end
        check("bp_rdata_held", held, 32'h12345678);
        req_valid = 1'b0;
        bp_hold = 0;
        drain();
        send(0, 2'b01, 32'h40, 32'h0, 1); drain();
        check("bp_ignored_store", last_rdata, 32'h0);

        // Reset on the final BUSY cycle of a store aborts it silently.
        send(1, 2'b00, 32'd8, 32'hDEADBEEF, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        send(0, 2'b01, 32'd8, 32'h0, 1); drain();
        check("abort_lw8", last_rdata, 32'h0);

        // Randomized traffic with random response back-pressure.
        bp_rand = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom % 8)
                7:       a = $urandom;
                6:       a = $urandom_range(1012, 1023);
                default: a = $urandom_range(0, 63);
            endcase
            send(($urandom % 3) == 0, 2'($urandom), a, $urandom, 1);
        end
        drain();
        bp_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
